mod_i2s_tx: RTL

- Downstream consumer of the sine source's signed 32-bit sample stream.
- Buffers samples in a small FIFO and serializes each one as a stereo I2S frame (same sample on left and right), MSB first, for the board audio DAC.
- Generates BCLK and LRCLK internally from the system clock.
- Flags FIFO underrun so the control side can detect starvation.

---
 rtl/mod_i2s_tx.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/mod_i2s_tx.sv
// ---------------------------------------------------------------------------
// mod_i2s_tx
//
// Purpose: buffers the signed 32-bit sample stream in a small FIFO and plays
// each sample out as one stereo I2S frame (same word on left and right),
// MSB first, with the standard one-BCLK data delay after LRCLK changes.
// BCLK and LRCLK are derived from i_clk. An empty FIFO at frame start sends
// silence and raises a sticky underrun flag.
//
// Optional feature (macro MOD_I2S_TX_SAT24_EN): when defined, each fetched
// sample is clamped to the signed 24-bit range and sent left-justified
// (low 8 bits zero). When undefined, the 32 bits are sent verbatim.
//
// Parameters:
//   CLK_DIV     i_clk cycles per BCLK half-period (>= 1)
//   FIFO_DEPTH  sample FIFO entries (power of two, >= 2)
//
// Ports:
//   i_clk           system clock
//   i_rst_n         asynchronous active-low reset
//   i_sample        signed sample to queue
//   i_valid         i_sample valid
//   o_ready         FIFO can accept (= !full)
//   i_clr_underrun  clears o_underrun
//   o_level         FIFO occupancy
//   o_underrun      sticky underrun flag
//   o_bclk          I2S bit clock
//   o_lrclk         word select, 0 = left, 1 = right
//   o_sdata         serial data
//
// Handshake: a word is taken in every cycle where i_valid && o_ready at the
// rising edge of i_clk. o_ready depends only on the registered full flag, so
// a pop in the same cycle never lets a write into a full FIFO, and a write
// offered while full is dropped with no side effect.
// ---------------------------------------------------------------------------
module mod_i2s_tx #(
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [31:0]                   i_sample,
  input  logic                          i_valid,
  output logic                          o_ready,
  input  logic                          i_clr_underrun,
  output logic [$clog2(FIFO_DEPTH):0]   o_level,
  output logic                          o_underrun,
  output logic                          o_bclk,
  output logic                          o_lrclk,
  output logic                          o_sdata
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  // -------------------------------------------------------------------------
  // Sample conditioning applied at fetch time
  // -------------------------------------------------------------------------
  function automatic logic [31:0] shape_word(input logic [31:0] x);
`ifdef MOD_I2S_TX_SAT24_EN
    logic signed [31:0] v;
    v = signed'(x);
    if (v > 32'sd8388607)
      return 32'h7FFF_FF00;
    else if (v < -32'sd8388608)
      return 32'h8000_0000;
    else
      return {x[23:0], 8'h00};
`else
    return x;
`endif
  endfunction

  // -------------------------------------------------------------------------
  // Sample FIFO
  // -------------------------------------------------------------------------
  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          fetch;

  assign full    = (level == LW'(FIFO_DEPTH));
  assign empty   = (level == '0);
  assign o_ready = ~full;
  assign push    = i_valid & ~full;
  assign pop     = fetch & ~empty;
  assign o_level = level;

  // Storage carries no reset: the pointers and level define what is valid.
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= i_sample;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // BCLK generation
  // -------------------------------------------------------------------------
  logic [DW-1:0] div_cnt;
  logic          div_wrap;
  logic          bclk_fall;

  assign div_wrap  = (div_cnt == DW'(CLK_DIV - 1));
  // The cycle in which the registered BCLK goes 1 -> 0.
  assign bclk_fall = div_wrap & o_bclk;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      div_cnt <= '0;
      o_bclk  <= 1'b0;
    end else if (div_wrap) begin
      div_cnt <= '0;
      o_bclk  <= ~o_bclk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Slot counter, word select and serializer
  // -------------------------------------------------------------------------
  logic [5:0]  slot;
  logic [5:0]  slot_nxt;
  logic [31:0] shreg;
  logic [31:0] fetch_word;

  assign slot_nxt   = slot + 6'd1;
  // A new frame's word is fetched on the fall that moves the slot 0 -> 1.
  assign fetch      = bclk_fall & (slot == 6'd0);
  assign fetch_word = empty ? 32'h0 : shape_word(mem[rd_ptr]);

  // The shift register rotates rather than shifts: after the 32 left bits
  // the same word is back in place for the right channel, and its bit 0
  // lands in slot 0 of the following frame (one-bit I2S delay).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      slot    <= '0;
      o_lrclk <= 1'b0;
      o_sdata <= 1'b0;
      shreg   <= '0;
    end else if (bclk_fall) begin
      slot    <= slot_nxt;
      o_lrclk <= slot_nxt[5];
      if (fetch) begin
        o_sdata <= fetch_word[31];
        shreg   <= {fetch_word[30:0], fetch_word[31]};
      end else begin
        o_sdata <= shreg[31];
        shreg   <= {shreg[30:0], shreg[31]};
      end
    end
  end

  // -------------------------------------------------------------------------
  // Sticky underrun flag; a new underrun wins over a coincident clear
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      o_underrun <= 1'b0;
    else if (fetch && empty)
      o_underrun <= 1'b1;
    else if (i_clr_underrun)
      o_underrun <= 1'b0;
  end

endmodule
